// File: rtl/cpu_run_monitor_if.sv
// CPU-side debug bus of the run monitor: the retire stream in, the reg_sel/reg_data probe, and the dump stream out.
// The master drives commits and reg data; the slave (the monitor) drives reg_sel and the dump outputs.
interface cpu_run_monitor_if #(
  parameter int XLEN = 32
) ();
  logic            commit_valid;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] instr_in;
  logic [4:0]      reg_sel_out;
  logic [XLEN-1:0] reg_data_in;
  logic            dump_valid;
  logic [4:0]      dump_idx;
  logic [XLEN-1:0] dump_data;

  modport master (
    output commit_valid, pc_in, instr_in, reg_data_in,
    input  reg_sel_out, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  commit_valid, pc_in, instr_in, reg_data_in,
    output reg_sel_out, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run monitor: traces retired instructions, stops on halt (self-loop) or timeout, then dumps NREGS registers (1-cycle latency).
// No backpressure: commits are sampled every RUN cycle, the dump streams once per cycle. Optional rd_cycle port: TRACE_TIMESTAMP_EN.
module cpu_run_monitor #(
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int MAX_CYCLES  = 200,
  parameter int HALT_REPEAT = 4,
  parameter int NREGS       = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  cpu_run_monitor_if.slave              mon,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]               rd_pc,
  output logic [XLEN-1:0]               rd_instr,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]                   rd_cycle,
`endif
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic [31:0]                   cycle_count,
  output logic [1:0]                    status,
  output logic                          done
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] STAT_RUN     = 2'd0;
  localparam logic [1:0] STAT_HALT    = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   trace_count_q, trace_count_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [31:0]     repeat_cnt_q, repeat_cnt_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            last_vld_q, last_vld_d;
  logic [1:0]      status_q, status_d;
  logic            done_q, done_d;
  logic [4:0]      reg_sel_q, reg_sel_d;
  logic            dump_valid_q, dump_valid_d;
  logic [4:0]      dump_idx_q, dump_idx_d;
  logic [XLEN-1:0] dump_data_q, dump_data_d;

  logic [XLEN-1:0] trace_pc_q    [TRACE_DEPTH];
  logic [XLEN-1:0] trace_instr_q [TRACE_DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]     trace_cyc_q   [TRACE_DEPTH];
`endif

  logic        commit;
  logic        halt_fire;
  logic        timeout_fire;
  logic [31:0] rep_next;

  always_comb begin
    commit       = mon.commit_valid && (state_q == ST_RUN);
    // last_vld keeps the very first commit (even at PC 0) from matching the cleared last_pc
    rep_next     = (last_vld_q && (mon.pc_in == last_pc_q)) ? repeat_cnt_q + 32'd1 : 32'd0;
    halt_fire    = commit && (rep_next == 32'(HALT_REPEAT - 1));
    timeout_fire = (state_q == ST_RUN) && (cycle_count_q == 32'(MAX_CYCLES - 1)) && !halt_fire;

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    trace_count_d = trace_count_q;
    cycle_count_d = cycle_count_q;
    repeat_cnt_d  = repeat_cnt_q;
    last_pc_d     = last_pc_q;
    last_vld_d    = last_vld_q;
    status_d      = status_q;
    done_d        = done_q;
    reg_sel_d     = reg_sel_q;
    dump_valid_d  = 1'b0;
    dump_idx_d    = dump_idx_q;
    dump_data_d   = dump_data_q;

    case (state_q)
      ST_RUN: begin
        if (commit) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          last_pc_d    = mon.pc_in;
          last_vld_d   = 1'b1;
          repeat_cnt_d = rep_next;
          if (trace_count_q != CW'(TRACE_DEPTH)) begin
            trace_count_d = trace_count_q + 1'b1;
          end
        end
        if (halt_fire) begin
          status_d = STAT_HALT;
          state_d  = ST_DUMP;
        end else if (timeout_fire) begin
          status_d = STAT_TIMEOUT;
          state_d  = ST_DUMP;
        end else begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
      ST_DUMP: begin
        dump_valid_d = 1'b1;
        dump_idx_d   = reg_sel_q;
        dump_data_d  = mon.reg_data_in;
        if (reg_sel_q == 5'(NREGS - 1)) begin
          reg_sel_d = 5'd0;
          state_d   = ST_DONE;
        end else begin
          reg_sel_d = reg_sel_q + 5'd1;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= '0;
      trace_count_q <= '0;
      cycle_count_q <= '0;
      repeat_cnt_q  <= '0;
      last_pc_q     <= '0;
      last_vld_q    <= 1'b0;
      status_q      <= STAT_RUN;
      done_q        <= 1'b0;
      reg_sel_q     <= '0;
      dump_valid_q  <= 1'b0;
      dump_idx_q    <= '0;
      dump_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      trace_count_q <= trace_count_d;
      cycle_count_q <= cycle_count_d;
      repeat_cnt_q  <= repeat_cnt_d;
      last_pc_q     <= last_pc_d;
      last_vld_q    <= last_vld_d;
      status_q      <= status_d;
      done_q        <= done_d;
      reg_sel_q     <= reg_sel_d;
      dump_valid_q  <= dump_valid_d;
      dump_idx_q    <= dump_idx_d;
      dump_data_q   <= dump_data_d;
    end
  end

  // Storage is not cleared on reset; trace_count gates every read instead
  always_ff @(posedge clk) begin
    if (rstn && commit) begin
      trace_pc_q[wr_ptr_q]    <= mon.pc_in;
      trace_instr_q[wr_ptr_q] <= mon.instr_in;
`ifdef TRACE_TIMESTAMP_EN
      trace_cyc_q[wr_ptr_q]   <= cycle_count_q;
`endif
    end
  end

  logic [PW-1:0] rd_addr;
  logic          rd_hit;

  always_comb begin
    rd_addr  = wr_ptr_q - trace_count_q[PW-1:0] + rd_idx;
    rd_hit   = ({1'b0, rd_idx} < trace_count_q);
    rd_pc    = rd_hit ? trace_pc_q[rd_addr]    : '0;
    rd_instr = rd_hit ? trace_instr_q[rd_addr] : '0;
`ifdef TRACE_TIMESTAMP_EN
    rd_cycle = rd_hit ? trace_cyc_q[rd_addr]   : '0;
`endif
  end

  assign mon.reg_sel_out = reg_sel_q;
  assign mon.dump_valid  = dump_valid_q;
  assign mon.dump_idx    = dump_idx_q;
  assign mon.dump_data   = dump_data_q;
  assign trace_count     = trace_count_q;
  assign cycle_count     = cycle_count_q;
  assign status          = status_q;
  assign done            = done_q;
endmodule
